// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO blocks: the write-arbiter state encoding,
// the default write-enable hold length and the counter width that carries it.
package fifo_write_arbiter_pkg;

    // Default number of cycles fifo_write_en stays high for one write.
    localparam int WRITE_CYCLES_DEFAULT = 2;

    // The write-length counter is 4 bits, so a write lasts 1..15 cycles.
    localparam int CNT_W            = 4;
    localparam int WRITE_CYCLES_MIN = 1;
    localparam int WRITE_CYCLES_MAX = 15;

    // Write arbiter FSM encoding. IDLE is zero so a cleared register means idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } fifo_state_e;

    // Converts the WRITE_CYCLES parameter into the counter load value.
    // Out-of-range settings are clamped so the counter can never wrap.
    function automatic logic [CNT_W-1:0] write_count_init(input int cycles);
        logic [CNT_W-1:0] value;
        if (cycles < WRITE_CYCLES_MIN) begin
            value = CNT_W'(WRITE_CYCLES_MIN);
        end else if (cycles > WRITE_CYCLES_MAX) begin
            value = CNT_W'(WRITE_CYCLES_MAX);
        end else begin
            value = CNT_W'(cycles);
        end
        return value;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter_2.sv
// Two-way round-robin decision. Purely combinational: the caller owns the
// last-grant pointer and decides when a grant is actually taken.
module rr_arbiter_2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,       // 1 = B was granted most recently
    output logic grant_valid,  // at least one requester is asking
    output logic grant_b       // 0 = grant A, 1 = grant B (meaningful when grant_valid)
);

    // Pick the sole requester, or on contention the one not granted last.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_b     = last_b;
        unique case ({req_a, req_b})
            2'b10:   grant_b = 1'b0;
            2'b01:   grant_b = 1'b1;
            2'b11:   grant_b = ~last_b;
            default: grant_b = last_b;
        endcase
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates two requesters onto a single FIFO write port.
//
// Handshake: a requester raises req with stable data and holds both until it
// sees its one-cycle ack pulse; it drops req in the cycle ack is observed.
// A req still high in the IDLE cycle after ACK is a new request. A grant is
// only issued from IDLE while fifo_full is low; once granted, the write runs
// to completion (fifo_full and req are ignored) unless reset intervenes, in
// which case no ack is given and the requester is re-arbitrated afresh.
//
// Timing per write: grant edge -> fifo_write_en high for WRITE_CYCLES cycles
// -> one ACK cycle -> IDLE for at least one cycle.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WRITE_CYCLES = WRITE_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic                  ack_a,
    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  ack_b,
    input  logic                  fifo_full,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  busy,
    output logic                  grant_b,
    output logic [1:0]            dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = write_count_init(WRITE_CYCLES);

    fifo_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  grant_b_q, grant_b_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  write_en_q, write_en_d;

    logic                  arb_valid;
    logic                  arb_grant_b;
    logic                  start_write;

    rr_arbiter_2 u_rr_arbiter_2 (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_b      (grant_b_q),
        .grant_valid (arb_valid),
        .grant_b     (arb_grant_b)
    );

    // A grant is taken only from IDLE and only while the FIFO has room.
    assign start_write = (state_q == ST_IDLE) && arb_valid && !fifo_full;

    // State and registered outputs; reset wins over everything, even mid-write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_b_q  <= 1'b1;
            data_q     <= '0;
            write_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_b_q  <= grant_b_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
        end
    end

    // Next-state: IDLE -> WRITE on grant, WRITE -> ACK when the count is spent,
    // ACK -> IDLE unconditionally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: next values of the registered write port plus the decoded
    // ack/busy strobes, which come straight from the state register.
    always_comb begin
        cnt_d      = cnt_q;
        grant_b_d  = grant_b_q;
        data_d     = data_q;
        write_en_d = 1'b0;
        ack_a      = 1'b0;
        ack_b      = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    // The holding register doubles as the FIFO data output, so
                    // the data is already on fifo_data_in when write_en rises.
                    grant_b_d = arb_grant_b;
                    data_d    = arb_grant_b ? data_b : data_a;
                    cnt_d     = CNT_LOAD;
                end
            end
            ST_WRITE: begin
                if (cnt_q != '0) begin
                    write_en_d = 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                ack_a = ~grant_b_q;
                ack_b = grant_b_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign fifo_write_en = write_en_q;
    assign fifo_data_in  = data_q;
    assign grant_b       = grant_b_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. Each write that stimulus expects is
// queued as {grant_b, data}; a negedge monitor pops it when an ack appears.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_fifo_write_arbiter;

    localparam int W = 9;

    logic       clock;
    logic       reset_n;

    // Default instance (WRITE_CYCLES = 2)
    logic       req_a, req_b, ack_a, ack_b;
    logic [7:0] data_a, data_b;
    logic       fifo_full, fifo_write_en, busy, grant_b;
    logic [7:0] fifo_data_in;
    logic [1:0] dbg_state;

    // Single-cycle instance (WRITE_CYCLES = 1)
    logic       req_a1, req_b1, ack_a1, ack_b1;
    logic [7:0] data_a1, data_b1;
    logic       fifo_full1, fifo_write_en1, busy1, grant_b1;
    logic [7:0] fifo_data_in1;
    logic [1:0] dbg_state1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    // Monitor state for the default instance
    bit         prev_we = 1'b0;
    int         run_len = 0;
    logic [7:0] run_data = '0;

    fifo_write_arbiter #(.DATA_WIDTH(8), .WRITE_CYCLES(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_a         (req_a),
        .data_a        (data_a),
        .ack_a         (ack_a),
        .req_b         (req_b),
        .data_b        (data_b),
        .ack_b         (ack_b),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .busy          (busy),
        .grant_b       (grant_b),
        .dbg_state     (dbg_state)
    );

    fifo_write_arbiter #(.DATA_WIDTH(8), .WRITE_CYCLES(1)) dut1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_a         (req_a1),
        .data_a        (data_a1),
        .ack_a         (ack_a1),
        .req_b         (req_b1),
        .data_b        (data_b1),
        .ack_b         (ack_b1),
        .fifo_full     (fifo_full1),
        .fifo_write_en (fifo_write_en1),
        .fifo_data_in  (fifo_data_in1),
        .busy          (busy1),
        .grant_b       (grant_b1),
        .dbg_state     (dbg_state1)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: track each write_en run and score it against the queue on ack
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_we = 1'b0;
        end else begin
            if (fifo_write_en) begin
                if (!prev_we) begin
                    run_len  = 1;
                    run_data = fifo_data_in;
                end else begin
                    run_len++;
                    `CHK("data_stable", fifo_data_in, run_data)
                end
            end
            prev_we = fifo_write_en;
            if (ack_a || ack_b) begin
                `CHK("ack_onehot", (ack_a & ack_b), 1'b0)
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_ack observed=ack_a:%0b/ack_b:%0b expected=no ack", ack_a, ack_b);
                end else begin
                    exp_e = exp_q.pop_front();
                    `CHK("sb_ack_b", ack_b, exp_e[8])
                    `CHK("sb_grant_b", grant_b, exp_e[8])
                    `CHK("sb_data", run_data, exp_e[7:0])
                    `CHK("sb_run_len", run_len, 2)
                end
            end
        end
    end

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = ack_a | ack_b;
        end
        `CHK("ack_timeout", seen, 1'b1)
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Directed stimulus
    initial begin
        reset_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; fifo_full = 1'b0;
        req_a1 = 1'b0; req_b1 = 1'b0; data_a1 = '0; data_b1 = '0; fifo_full1 = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        `CHK("rst_we", fifo_write_en, 1'b0)
        `CHK("rst_ack_a", ack_a, 1'b0)
        `CHK("rst_ack_b", ack_b, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_grant_b", grant_b, 1'b1)
        `CHK("rst_data", fifo_data_in, 8'h00)
        `CHK("rst_state", dbg_state, 2'b00)
        reset_n = 1'b1;
        @(negedge clock);

        // Single write from A with cycle-exact latency
        req_a = 1'b1; data_a = 8'h11;
        exp_q.push_back({1'b0, 8'h11});
        @(negedge clock);
        `CHK("t1_busy_grant", busy, 1'b1)
        `CHK("t1_we_not_yet", fifo_write_en, 1'b0)
        `CHK("t1_grant_b", grant_b, 1'b0)
        @(negedge clock);
        `CHK("t1_we1", fifo_write_en, 1'b1)
        `CHK("t1_data1", fifo_data_in, 8'h11)
        @(negedge clock);
        `CHK("t1_we2", fifo_write_en, 1'b1)
        `CHK("t1_data2", fifo_data_in, 8'h11)
        @(negedge clock);
        `CHK("t1_we_off", fifo_write_en, 1'b0)
        `CHK("t1_ack_a", ack_a, 1'b1)
        req_a = 1'b0;
        @(negedge clock);
        `CHK("t1_ack_gone", ack_a, 1'b0)
        `CHK("t1_idle", busy, 1'b0)

        // Contention after reset: A first, then B
        do_reset();
        req_a = 1'b1; data_a = 8'hA1; req_b = 1'b1; data_b = 8'hB2;
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB2});
        wait_ack();
        `CHK("t2_first_ack_a", ack_a, 1'b1)
        `CHK("t2_first_grant", grant_b, 1'b0)
        req_a = 1'b0;
        wait_ack();
        `CHK("t2_second_ack_b", ack_b, 1'b1)
        `CHK("t2_second_grant", grant_b, 1'b1)
        req_b = 1'b0;
        @(negedge clock);

        // FIFO full blocks the grant; full during the write is ignored
        fifo_full = 1'b1; req_b = 1'b1; data_b = 8'hC3;
        exp_q.push_back({1'b1, 8'hC3});
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            `CHK("t3_full_no_we", fifo_write_en, 1'b0)
            `CHK("t3_full_idle", busy, 1'b0)
        end
        fifo_full = 1'b0;
        @(negedge clock);
        `CHK("t3_start_after_full", busy, 1'b1)
        fifo_full = 1'b1;
        wait_ack();
        `CHK("t3_ack_b", ack_b, 1'b1)
        req_b = 1'b0; fifo_full = 1'b0;
        @(negedge clock);

        // Reset mid-write: no ack, then the held request is served once
        req_a = 1'b1; data_a = 8'h5A;
        exp_q.push_back({1'b0, 8'h5A});
        @(negedge clock);
        @(negedge clock);
        `CHK("t4_we_before_rst", fifo_write_en, 1'b1)
        reset_n = 1'b0;
        @(negedge clock);
        `CHK("t4_rst_we", fifo_write_en, 1'b0)
        `CHK("t4_rst_ack", {ack_a, ack_b}, 2'b00)
        `CHK("t4_rst_busy", busy, 1'b0)
        `CHK("t4_rst_grant_b", grant_b, 1'b1)
        `CHK("t4_rst_data", fifo_data_in, 8'h00)
        reset_n = 1'b1;
        wait_ack();
        `CHK("t4_reserve_ack_a", ack_a, 1'b1)
        req_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            `CHK("t4_served_once", busy, 1'b0)
        end

        // Continuous requests from A, one IDLE cycle between writes
        req_a = 1'b1; data_a = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({1'b0, 8'(k)});
        end
        for (int k = 1; k <= 4; k++) begin
            wait_ack();
            `CHK("t5_ack_a", ack_a, 1'b1)
            data_a = 8'(k + 1);
            if (k == 4) req_a = 1'b0;
            @(negedge clock);
            `CHK("t5_idle_gap", busy, 1'b0)
            if (k < 4) begin
                @(negedge clock);
                `CHK("t5_regrant", busy, 1'b1)
            end
        end
        @(negedge clock);

        // Request withdrawn mid-write still completes and acks
        req_a = 1'b1; data_a = 8'h99;
        exp_q.push_back({1'b0, 8'h99});
        @(negedge clock);
        `CHK("t7_busy", busy, 1'b1)
        req_a = 1'b0;
        wait_ack();
        `CHK("t7_ack_a", ack_a, 1'b1)
        @(negedge clock);

        // One-cycle write instance
        req_b1 = 1'b1; data_b1 = 8'h7E;
        @(negedge clock);
        `CHK("t6_busy", busy1, 1'b1)
        `CHK("t6_we_not_yet", fifo_write_en1, 1'b0)
        @(negedge clock);
        `CHK("t6_we", fifo_write_en1, 1'b1)
        `CHK("t6_data", fifo_data_in1, 8'h7E)
        `CHK("t6_no_ack_yet", ack_b1, 1'b0)
        @(negedge clock);
        `CHK("t6_we_off", fifo_write_en1, 1'b0)
        `CHK("t6_ack_b", ack_b1, 1'b1)
        `CHK("t6_ack_a", ack_a1, 1'b0)
        req_b1 = 1'b0;
        @(negedge clock);
        `CHK("t6_idle", busy1, 1'b0)

        // Every expected write must have been acknowledged
        `CHK("queue_empty", exp_q.size(), 0)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
